// File: rtl/i2c_target_pkg.sv
// ============================================================================
//  Module      : i2c_target_pkg
//  Description : Shared constants for the I2C target: target FSM state
//                encodings, the byte bit count and a bit-shift helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_target_pkg;

  // Target FSM state encodings (shared with the controller's view of the bus)
  localparam logic [3:0] k_t_idle      = 4'd0;
  localparam logic [3:0] k_t_addr      = 4'd1;
  localparam logic [3:0] k_t_addr_ack  = 4'd2;
  localparam logic [3:0] k_t_rx        = 4'd3;
  localparam logic [3:0] k_t_rx_ack    = 4'd4;
  localparam logic [3:0] k_t_tx_load   = 4'd5;
  localparam logic [3:0] k_t_tx        = 4'd6;
  localparam logic [3:0] k_t_tx_ack    = 4'd7;
  localparam logic [3:0] k_t_wait_stop = 4'd8;

  // Bits per byte on the wire (ACK bit not included)
  localparam logic [3:0] k_bit_count   = 4'd8;

  // MSB-first shift of one sampled bit into a byte
  function automatic logic [7:0] shift_in(input logic [7:0] s, input logic b);
    return {s[6:0], b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_bus_sync.sv
// ============================================================================
//  Module      : i2c_bus_sync
//  Description : Two-flop synchronizers on SCL and SDA followed by a one-flop
//                edge detector. Produces the synchronized SDA level plus
//                SCL rise/fall and START/STOP strobes.
//  Ports       : clk, reset        - clock, async active-high reset
//                scl_in, sda_in    - raw pin levels
//                sda               - synchronized SDA level
//                scl_rise/scl_fall - one-cycle SCL edge strobes
//                start_det         - SDA fell while SCL high
//                stop_det          - SDA rose while SCL high
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d;
  logic       sda_prev_q, sda_prev_d;
  logic       w_scl;

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_in};
    sda_sync_d = {sda_sync_q[0], sda_in};
    scl_prev_d = scl_sync_q[1];
    sda_prev_d = sda_sync_q[1];
  end

  // Everything resets high so an idle bus produces no edges after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign w_scl     = scl_sync_q[1];
  assign sda       = sda_sync_q[1];
  assign scl_rise  =  w_scl & ~scl_prev_q;
  assign scl_fall  = ~w_scl &  scl_prev_q;
  // SCL must have been high in both samples, so an SDA change that coincides
  // with an SCL edge is never taken as START/STOP.
  assign start_det = w_scl & scl_prev_q &  sda_prev_q & ~sda;
  assign stop_det  = w_scl & scl_prev_q & ~sda_prev_q &  sda;

endmodule

`default_nettype wire

// File: rtl/i2c_target.sv
// ============================================================================
//  Module      : i2c_target
//  Description : I2C target (responder). Detects START / repeated START /
//                STOP, matches a 7-bit address, ACKs, streams write bytes to
//                the user and shifts user bytes out on reads, stretching SCL
//                while no read byte is available.
//  Ports       : clk, reset          - clock, async active-high reset
//                scl_in, sda_in      - raw bus levels
//                scl_oe, sda_oe      - 1 = pull the line low
//                rx_data, rx_valid   - received write byte + one-cycle strobe
//                tx_data, tx_valid,
//                tx_ready            - read byte handshake
//                addressed, rw, busy - transfer status
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] ADDR        = 7'h42,
  parameter int         HOLD_CYCLES = 4,
  parameter bit         STRETCH_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       addressed,
  output logic       rw,
  output logic       busy
);

  localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda       (w_sda),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start),
    .stop_det  (w_stop)
  );

  logic [3:0]        state_q, state_d;
  logic [3:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              rw_q, rw_d;
  logic              addressed_q, addressed_d;
  logic              busy_q, busy_d;
  logic              sda_oe_q, sda_oe_d;
  logic              scl_oe_q, scl_oe_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tx_ready_q, tx_ready_d;
  // SDA changes are deferred: hold_cnt counts down after an SCL fall and
  // sda_next is applied to sda_oe when it expires.
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              sda_next_q, sda_next_d;

  logic [7:0]        w_shift;
  logic              w_tx_hs;
  logic              w_last_bit;

  assign w_shift    = shift_in(shreg_q, w_sda);
  assign w_tx_hs    = tx_valid & tx_ready_q;
  assign w_last_bit = (bitcnt_q == k_bit_count - 4'd1);

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    rw_d        = rw_q;
    addressed_d = addressed_q;
    busy_d      = busy_q;
    sda_oe_d    = sda_oe_q;
    scl_oe_d    = scl_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_ready_d  = tx_ready_q;
    hold_cnt_d  = hold_cnt_q;
    sda_next_d  = sda_next_q;

    if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - HOLD_ONE;
      if (hold_cnt_q == HOLD_ONE) begin
        sda_oe_d = sda_next_q;
      end
    end

    // Bus conditions take priority over any bit-level action.
    if (w_stop) begin
      state_d     = k_t_idle;
      bitcnt_d    = '0;
      busy_d      = 1'b0;
      addressed_d = 1'b0;
      sda_oe_d    = 1'b0;
      scl_oe_d    = 1'b0;
      tx_ready_d  = 1'b0;
      hold_cnt_d  = '0;
      sda_next_d  = 1'b0;
    end else if (w_start) begin
      state_d     = k_t_addr;
      bitcnt_d    = '0;
      busy_d      = 1'b1;
      addressed_d = 1'b0;
      tx_ready_d  = 1'b0;
      // SCL is high here, so we cannot be stretching; SDA release is timed
      // like any other SDA change.
      scl_oe_d    = 1'b0;
      hold_cnt_d  = HOLD_LOAD;
      sda_next_d  = 1'b0;
    end else begin
      case (state_q)
        k_t_addr: begin
          if (w_scl_rise) begin
            shreg_d  = w_shift;
            bitcnt_d = bitcnt_q + 4'd1;
            if (w_last_bit) begin
              bitcnt_d = '0;
              if (w_shift[7:1] == ADDR) begin
                rw_d    = w_shift[0];
                state_d = k_t_addr_ack;
              end else begin
                state_d = k_t_wait_stop;
              end
            end
          end
        end

        // bitcnt marks whether the ACK clock has risen: 0 before, 1 after.
        k_t_addr_ack, k_t_rx_ack: begin
          if (w_scl_fall && bitcnt_q == 4'd0) begin
            hold_cnt_d = HOLD_LOAD;
            sda_next_d = 1'b1;
          end else if (w_scl_rise) begin
            bitcnt_d = 4'd1;
            if (state_q == k_t_addr_ack) begin
              addressed_d = 1'b1;
            end
          end else if (w_scl_fall) begin
            bitcnt_d   = '0;
            hold_cnt_d = HOLD_LOAD;
            sda_next_d = 1'b0;
            if (state_q == k_t_rx_ack || !rw_q) begin
              state_d = k_t_rx;
            end else begin
              state_d    = k_t_tx_load;
              tx_ready_d = 1'b1;
            end
          end
        end

        k_t_rx: begin
          if (w_scl_rise) begin
            shreg_d  = w_shift;
            bitcnt_d = bitcnt_q + 4'd1;
            if (w_last_bit) begin
              rx_data_d  = w_shift;
              rx_valid_d = 1'b1;
              bitcnt_d   = '0;
              state_d    = k_t_rx_ack;
            end
          end
        end

        k_t_tx_load: begin
          if (w_tx_hs) begin
            shreg_d    = tx_data;
            tx_ready_d = 1'b0;
            scl_oe_d   = 1'b0;
            bitcnt_d   = '0;
            state_d    = k_t_tx;
            if (scl_oe_q) begin
              // SCL goes high on this same edge; putting bit 7 out together
              // with the release keeps SDA stable for the whole high phase.
              sda_oe_d   = ~tx_data[7];
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = HOLD_LOAD;
              sda_next_d = ~tx_data[7];
            end
          end else if (STRETCH_EN) begin
            scl_oe_d = 1'b1;
          end else if (w_scl_rise) begin
            // No byte and no stretching: bit 7 is already being sampled with
            // SDA released, so the byte on the wire is all ones.
            shreg_d    = 8'hFF;
            tx_ready_d = 1'b0;
            bitcnt_d   = '0;
            state_d    = k_t_tx;
          end
        end

        k_t_tx: begin
          if (w_scl_fall) begin
            hold_cnt_d = HOLD_LOAD;
            if (w_last_bit) begin
              sda_next_d = 1'b0;
              bitcnt_d   = '0;
              state_d    = k_t_tx_ack;
            end else begin
              shreg_d    = {shreg_q[6:0], 1'b1};
              sda_next_d = ~shreg_q[6];
              bitcnt_d   = bitcnt_q + 4'd1;
            end
          end
        end

        k_t_tx_ack: begin
          if (w_scl_rise) begin
            if (!w_sda) begin
              bitcnt_d = 4'd1;
            end else begin
              addressed_d = 1'b0;
              state_d     = k_t_wait_stop;
            end
          end else if (w_scl_fall && bitcnt_q == 4'd1) begin
            bitcnt_d   = '0;
            state_d    = k_t_tx_load;
            tx_ready_d = 1'b1;
          end
        end

        default: begin
          // k_t_idle / k_t_wait_stop: only START or STOP moves us on.
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= k_t_idle;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      rw_q        <= 1'b0;
      addressed_q <= 1'b0;
      busy_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      scl_oe_q    <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_ready_q  <= 1'b0;
      hold_cnt_q  <= '0;
      sda_next_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      rw_q        <= rw_d;
      addressed_q <= addressed_d;
      busy_q      <= busy_d;
      sda_oe_q    <= sda_oe_d;
      scl_oe_q    <= scl_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_ready_q  <= tx_ready_d;
      hold_cnt_q  <= hold_cnt_d;
      sda_next_q  <= sda_next_d;
    end
  end

  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_ready  = tx_ready_q;
  assign addressed = addressed_q;
  assign rw        = rw_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_target.sv
// ============================================================================
//  Module      : tb_i2c_target
//  Description : Directed self-checking bench for i2c_target. A behavioural
//                open-drain bus controller drives SCL/SDA; the lines are the
//                wired-AND of controller and target pull-downs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_target;
  import i2c_target_pkg::*;

  localparam int Q = 20;   // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_low = 1'b0;
  logic       sda_low = 1'b0;
  logic       scl_in, sda_in, scl_oe, sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, addressed, rw, busy;

  int total = 0;
  int bad = 0;
  int rx_cnt = 0;
  int hs_cnt = 0;
  int oe_cycles = 0;
  logic [7:0] rx_log [0:15];

  assign scl_in = ~(scl_low | scl_oe);
  assign sda_in = ~(sda_low | sda_oe);

  always #5 clk = ~clk;

  i2c_target #(.ADDR(7'h42), .HOLD_CYCLES(4), .STRETCH_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .addressed (addressed),
    .rw        (rw),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt[3:0]] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (tx_valid && tx_ready) hs_cnt <= hs_cnt + 1;
    if (sda_oe) oe_cycles <= oe_cycles + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  // ---------------- bus controller primitives ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int k = 0;
    while (scl_in !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (scl_in !== 1'b1) begin
      total++; bad++;
      $display("FAIL scl_release_timeout: scl=%b want 1", scl_in);
    end
  endtask

  // One SCL pulse; pre=1 means SCL is already released by the controller.
  task automatic bus_bit(input logic b, input logic pre, output logic r);
    if (!pre) begin
      sda_low = ~b;
      tick(Q);
      scl_low = 1'b0;
    end
    wait_scl_high();
    tick(Q);
    r = sda_in;
    tick(Q);
    scl_low = 1'b1;
    tick(Q);
  endtask

  task automatic bus_start();
    sda_low = 1'b0; tick(Q);
    scl_low = 1'b0; wait_scl_high(); tick(Q);
    sda_low = 1'b1; tick(Q);
    scl_low = 1'b1; tick(Q);
  endtask

  task automatic bus_stop();
    sda_low = 1'b1; tick(Q);
    scl_low = 1'b0; wait_scl_high(); tick(Q);
    sda_low = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], 1'b0, r);
    bus_bit(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(input logic pre, input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, (i == 7) ? pre : 1'b0, r);
      d[i] = r;
    end
    bus_bit(nack, 1'b0, r);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    total++;
    if ({scl_oe, sda_oe, rx_valid, tx_ready, addressed, rw, busy} !== 7'b0) begin
      bad++; $display("FAIL reset_outputs: got %b want 0000000",
                      {scl_oe, sda_oe, rx_valid, tx_ready, addressed, rw, busy});
    end
    total++;
    if (rx_data !== 8'h00) begin
      bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data);
    end
    reset = 1'b0;
    tick(5);
    total++;
    if (dut.state_q !== k_t_idle || busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle: state=%0d busy=%b want state=%0d busy=0",
                      dut.state_q, busy, k_t_idle);
    end
  endtask

  task automatic test_write();
    int rx0 = rx_cnt;
    int i1;
    logic ack;
    bus_start();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy: got %b want 1", busy); end
    write_byte(8'h84, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL wr_addr_ack: got %b want 0", ack); end
    total++;
    if (addressed !== 1'b1 || rw !== 1'b0) begin
      bad++; $display("FAIL wr_addressed_rw: got %b%b want 10", addressed, rw);
    end
    write_byte(8'hA5, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL wr_data1_ack: got %b want 0", ack); end
    write_byte(8'h3C, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL wr_data2_ack: got %b want 0", ack); end
    bus_stop();
    tick(5);
    total++;
    if (rx_cnt - rx0 !== 2) begin bad++; $display("FAIL wr_rx_count: got %0d want 2", rx_cnt - rx0); end
    i1 = (rx0 + 1) % 16;
    total++;
    if (rx_log[rx0 % 16] !== 8'hA5 || rx_log[i1] !== 8'h3C) begin
      bad++; $display("FAIL wr_rx_data: got %h %h want a5 3c", rx_log[rx0 % 16], rx_log[i1]);
    end
    total++;
    if (addressed !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL wr_after_stop: addressed=%b busy=%b want 0 0", addressed, busy);
    end
  endtask

  task automatic test_mismatch();
    int rx0 = rx_cnt;
    int oe0 = oe_cycles;
    logic ack;
    bus_start();
    write_byte(8'h86, ack);
    total++;
    if (ack !== 1'b1) begin bad++; $display("FAIL mm_addr_nack: got %b want 1", ack); end
    write_byte(8'h55, ack);
    total++;
    if (busy !== 1'b1 || addressed !== 1'b0) begin
      bad++; $display("FAIL mm_status: busy=%b addressed=%b want 1 0", busy, addressed);
    end
    bus_stop();
    tick(5);
    total++;
    if (oe_cycles !== oe0) begin bad++; $display("FAIL mm_sda_oe: got %0d cycles want 0", oe_cycles - oe0); end
    total++;
    if (rx_cnt !== rx0) begin bad++; $display("FAIL mm_rx_valid: got %0d pulses want 0", rx_cnt - rx0); end
  endtask

  task automatic test_read_nack();
    int hs0 = hs_cnt;
    logic ack;
    logic [7:0] d;
    tx_data = 8'h96;
    tx_valid = 1'b1;
    bus_start();
    write_byte(8'h85, ack);
    total++;
    if (ack !== 1'b0 || rw !== 1'b1) begin
      bad++; $display("FAIL rd_addr: ack=%b rw=%b want 0 1", ack, rw);
    end
    read_byte(1'b0, 1'b1, d);
    tx_valid = 1'b0;
    total++;
    if (d !== 8'h96) begin bad++; $display("FAIL rd_byte: got %h want 96", d); end
    total++;
    if (hs_cnt - hs0 !== 1) begin bad++; $display("FAIL rd_handshakes: got %0d want 1", hs_cnt - hs0); end
    total++;
    if (dut.state_q !== k_t_wait_stop || sda_oe !== 1'b0 || addressed !== 1'b0) begin
      bad++; $display("FAIL rd_nack_state: state=%0d sda_oe=%b addressed=%b want %0d 0 0",
                      dut.state_q, sda_oe, addressed, k_t_wait_stop);
    end
    bus_stop();
    tick(5);
  endtask

  task automatic test_stretch();
    int viol = 0;
    logic ack;
    logic [7:0] d;
    tx_valid = 1'b0;
    bus_start();
    write_byte(8'h85, ack);
    total++;
    if (ack !== 1'b0 || scl_oe !== 1'b1) begin
      bad++; $display("FAIL st_begin: ack=%b scl_oe=%b want 0 1", ack, scl_oe);
    end
    scl_low = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (scl_oe !== 1'b1 || scl_in !== 1'b0) viol++;
    end
    total++;
    if (viol !== 0) begin bad++; $display("FAIL st_hold: got %0d released cycles want 0", viol); end
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (scl_oe !== 1'b0 || tx_ready !== 1'b0) begin
      bad++; $display("FAIL st_release: scl_oe=%b tx_ready=%b want 0 0", scl_oe, tx_ready);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    read_byte(1'b1, 1'b1, d);
    total++;
    if (d !== 8'h5A) begin bad++; $display("FAIL st_byte: got %h want 5a", d); end
    bus_stop();
    tick(5);
  endtask

  task automatic test_rep_start();
    logic ack;
    logic [7:0] d;
    int il;
    bus_start();
    write_byte(8'h84, ack);
    write_byte(8'h11, ack);
    total++;
    if (ack !== 1'b0 || rw !== 1'b0) begin
      bad++; $display("FAIL rs_write: ack=%b rw=%b want 0 0", ack, rw);
    end
    il = (rx_cnt + 15) % 16;
    total++;
    if (rx_log[il] !== 8'h11) begin bad++; $display("FAIL rs_rx_data: got %h want 11", rx_log[il]); end
    tx_data = 8'hC3;
    tx_valid = 1'b1;
    bus_start();
    total++;
    if (busy !== 1'b1 || addressed !== 1'b0) begin
      bad++; $display("FAIL rs_restart: busy=%b addressed=%b want 1 0", busy, addressed);
    end
    write_byte(8'h85, ack);
    total++;
    if (ack !== 1'b0 || rw !== 1'b1 || addressed !== 1'b1) begin
      bad++; $display("FAIL rs_read_addr: ack=%b rw=%b addressed=%b want 0 1 1", ack, rw, addressed);
    end
    read_byte(1'b0, 1'b1, d);
    tx_valid = 1'b0;
    total++;
    if (d !== 8'hC3) begin bad++; $display("FAIL rs_byte: got %h want c3", d); end
    bus_stop();
    tick(5);
  endtask

  task automatic test_reset_mid();
    logic ack;
    logic r;
    tx_data = 8'h00;
    tx_valid = 1'b1;
    bus_start();
    write_byte(8'h85, ack);
    bus_bit(1'b1, 1'b0, r);
    tx_valid = 1'b0;
    sda_low = 1'b0;
    tick(Q);
    total++;
    if (sda_oe !== 1'b1) begin bad++; $display("FAIL rm_driving: sda_oe=%b want 1", sda_oe); end
    scl_low = 1'b0;
    wait_scl_high();
    tick(5);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({sda_oe, scl_oe, rx_valid, tx_ready, addressed} !== 5'b0) begin
      bad++; $display("FAIL rm_release: got %b want 00000",
                      {sda_oe, scl_oe, rx_valid, tx_ready, addressed});
    end
    tick(3);
    reset = 1'b0;
    tick(10);
    total++;
    if (dut.state_q !== k_t_idle || busy !== 1'b0) begin
      bad++; $display("FAIL rm_idle: state=%0d busy=%b want %0d 0", dut.state_q, busy, k_t_idle);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_mismatch();
    test_read_nack();
    test_stretch();
    test_rep_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
